shiftleft_iterative: RTL and testbench
======================================

# shiftleft_iterative

Multi-cycle logical left shifter for the processor datapath; the left-shift counterpart to the combinational arithmetic right-shift stages used for SRA. It accepts a 32-bit operand and a 5-bit shift amount with a start pulse, applies one binary-weighted shift stage per clock (16, 8, 4, 2, 1), and raises a one-cycle ready strobe with the result. It also reports whether any set bit was shifted out. It sits beside the multdiv unit and uses the same ctrl/ready handshake, so the pipeline stall logic treats both alike.

## Interface
- WIDTH, 32, operand/result width; must be a power of two ≥ 2
- SHAMT_W, $clog2(WIDTH) = 5, shift-amount width; also the number of stages and the latency in cycles
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- ctrl_shift  input  1  start strobe; sampled only when the unit is not busy
- data_operand  input  WIDTH  value to shift; captured on the accepting edge
- shift_amount  input  SHAMT_W  unsigned shift count; captured on the accepting edge
- data_result  output  WIDTH  shifted value; valid while data_resultRDY=1, held until the next accept
- data_resultRDY  output  1  one-cycle completion strobe
- data_overflow  output  1  1 if any 1 bit was shifted past bit WIDTH-1; valid with data_resultRDY, held with data_result
- busy  output  1  high from the cycle after accept through the final stage cycle

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if ctrl_shift=1, capture data_operand into the working register and shift_amount into the count register. Clear the overflow accumulator and the stage index. Go to SHIFT.
- SHIFT: stage index k runs 0..SHAMT_W-1.
  - At stage k, if count bit [SHAMT_W-1-k] is 1, working ← working << 2^(SHAMT_W-1-k), zero-filled from the LSB.
  - In the same cycle, overflow accumulator |= OR of the top 2^(SHAMT_W-1-k) bits of working before the shift.
  - If the count bit is 0, the register is unchanged.
  - After stage SHAMT_W-1, go to DONE.
- DONE: data_resultRDY=1 for this cycle only. data_result and data_overflow show the final values.
  - If ctrl_shift=1 in DONE, a new operation is accepted, exactly as in IDLE, and the FSM goes to SHIFT.
  - Otherwise the FSM goes to IDLE.
- ctrl_shift in SHIFT is ignored; it is neither queued nor an error.
- shift_amount=0 still takes the full latency and returns the operand unchanged with data_overflow=0.
- Latency is fixed and independent of the shift count, so stall timing is deterministic.
- data_result and data_overflow keep their last completed values in IDLE. They are not disturbed until the next DONE.

## Timing
- Accept edge = E0. Stages are applied on edges E1..E5. data_resultRDY is high in the cycle after E5 (latency 5 clocks for SHAMT_W=5). busy is high between E0 and E5.
- Back-to-back: an accept in DONE gives a throughput of one result per SHAMT_W+1 cycles.
- Reset values:
  - state: IDLE
  - data_result: 0
  - data_overflow: 0
  - data_resultRDY: 0
  - busy: 0
  - internal registers: 0
- Reset mid-operation aborts it. No data_resultRDY is issued for the aborted operation. The first ctrl_shift after reset deasserts starts a fresh operation.
- No combinational path from inputs to outputs; all outputs come from registers.

## Structure
- Shared package/header holds:
  - FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - default WIDTH and SHAMT_W constants
- Sub-module shiftleft_stage, purely combinational:
  - inputs: operand, stage amount, enable
  - outputs: shifted value and a spill flag (OR of the bits shifted out)
- The top level instantiates one shiftleft_stage and muxes its amount by stage index. It does not instantiate five fixed stages; this keeps the area iterative.

## Test plan
- 0x0000_0001, shift 31 → data_result 0x8000_0000, data_overflow 0, data_resultRDY exactly 5 cycles after accept, busy high 5 cycles.
- 0xF000_000F, shift 4 → 0x0000_00F0, data_overflow 1; then 0x0FFF_FFFF, shift 4 → 0xFFFF_FFF0, data_overflow 0.
- 0x1234_5678, shift 0 → 0x1234_5678, overflow 0, still 5-cycle latency. Then 0xFFFF_FFFF, shift 1 → 0xFFFF_FFFE, overflow 1.
- ctrl_shift pulsed during SHIFT with a different operand → ignored; the first result is unaffected and only one data_resultRDY occurs. ctrl_shift held high in the DONE cycle → second operation accepted with no idle gap.
- reset asserted asynchronously during stage 3 → all outputs 0 immediately, no data_resultRDY. After release, 0x0000_00FF, shift 8 → 0x0000_FF00.
- Randomised 1000 operand/shift pairs compared against (operand << shift) and a golden overflow check (operand >> (32-shift) ≠ 0, with shift=0 → 0).

Source files
------------

// File: rtl/shiftleft_iterative_pkg.sv
// Shared constants and FSM encoding for the
// iterative logical left shifter.
package shiftleft_iterative_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sl_state_t;

endpackage

// File: rtl/shiftleft_stage.sv
// One binary-weighted left-shift stage with a
// spill flag for the bits pushed past the MSB.
module shiftleft_stage
  import shiftleft_iterative_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               enable,
  output logic [WIDTH-1:0]   shifted,
  output logic               spill
);

  logic [WIDTH-1:0] top_mask;

  // top_mask selects the bits that leave the word
  assign top_mask = ~({WIDTH{1'b1}} >> amount);

  always_comb begin
    shifted = operand;
    spill   = 1'b0;
    if (enable) begin
      shifted = operand << amount;
      spill   = |(operand & top_mask);
    end
  end

endmodule

// File: rtl/shiftleft_iterative.sv
// Multi-cycle logical left shifter: one weighted
// stage per clock, fixed latency of SHAMT_W clocks.
module shiftleft_iterative
  import shiftleft_iterative_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_shift,
  input  logic [WIDTH-1:0]   data_operand,
  input  logic [SHAMT_W-1:0] shift_amount,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               data_overflow,
  output logic               busy
);

  localparam logic [SHAMT_W-1:0] MSB_AMT =
    SHAMT_W'(1) << (SHAMT_W - 1);
  localparam logic [SHAMT_W-1:0] LAST_K =
    SHAMT_W'(SHAMT_W - 1);

  sl_state_t          state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] k;
  logic               acc;

  logic [SHAMT_W-1:0] stg_amt;
  logic [WIDTH-1:0]   stg_out;
  logic               stg_spill;

  // stage k applies the weight 2^(SHAMT_W-1-k);
  // cnt is shifted up so its MSB is always the live bit
  assign stg_amt = MSB_AMT >> k;

  shiftleft_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_stage (
    .operand (work),
    .amount  (stg_amt),
    .enable  (cnt[SHAMT_W-1]),
    .shifted (stg_out),
    .spill   (stg_spill)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      work           <= '0;
      cnt            <= '0;
      k              <= '0;
      acc            <= 1'b0;
      data_result    <= '0;
      data_overflow  <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (ctrl_shift) begin
            work  <= data_operand;
            cnt   <= shift_amount;
            acc   <= 1'b0;
            k     <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work <= stg_out;
          cnt  <= cnt << 1;
          acc  <= acc | stg_spill;
          k    <= k + SHAMT_W'(1);
          if (k == LAST_K) begin
            data_result    <= stg_out;
            data_overflow  <= acc | stg_spill;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftleft_iterative.sv
// Self-checking bench: directed vectors plus a
// cycle-level reference model compared every cycle.
module tb_shiftleft_iterative;

  logic        clock;
  logic        reset;
  logic        ctrl_shift;
  logic [31:0] data_operand;
  logic [4:0]  shift_amount;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_overflow;
  logic        busy;

  int total = 0;
  int bad   = 0;

  shiftleft_iterative dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_shift     (ctrl_shift),
    .data_operand   (data_operand),
    .shift_amount   (shift_amount),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_overflow  (data_overflow),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] gres(input logic [31:0] op,
                                       input logic [4:0] sh);
    return op << sh;
  endfunction

  function automatic logic gov(input logic [31:0] op,
                               input logic [4:0] sh);
    int s;
    s = int'(sh);
    if (s == 0) return 1'b0;
    return (op >> (32 - s)) != 0;
  endfunction

  // reference: fixed 5-cycle countdown, results from plain arithmetic
  int          cyc_left;
  logic        m_rdy, m_busy, m_ovf, p_ovf;
  logic [31:0] m_res, p_res;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_left <= 0;
      m_rdy    <= 1'b0;
      m_busy   <= 1'b0;
      m_ovf    <= 1'b0;
      m_res    <= '0;
      p_ovf    <= 1'b0;
      p_res    <= '0;
    end else if (cyc_left != 0) begin
      cyc_left <= cyc_left - 1;
      m_rdy    <= 1'b0;
      if (cyc_left == 1) begin
        m_rdy  <= 1'b1;
        m_busy <= 1'b0;
        m_res  <= p_res;
        m_ovf  <= p_ovf;
      end
    end else begin
      m_rdy <= 1'b0;
      if (ctrl_shift) begin
        cyc_left <= 5;
        m_busy   <= 1'b1;
        p_res    <= gres(data_operand, shift_amount);
        p_ovf    <= gov(data_operand, shift_amount);
      end
    end
  end

  always @(negedge clock) begin
    check("cyc_rdy", {31'd0, data_resultRDY}, {31'd0, m_rdy});
    check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
    check("cyc_res", data_result, m_res);
    check("cyc_ovf", {31'd0, data_overflow}, {31'd0, m_ovf});
  end

  task automatic run_op(input logic [31:0] op,
                        input logic [4:0]  sh,
                        input logic [31:0] er,
                        input logic        eo,
                        input string       nm);
    int n, bc;
    @(negedge clock);
    ctrl_shift   = 1'b1;
    data_operand = op;
    shift_amount = sh;
    @(negedge clock);
    ctrl_shift = 1'b0;
    n  = 0;
    bc = 0;
    while (!data_resultRDY && n < 20) begin
      if (busy) bc++;
      @(negedge clock);
      n++;
    end
    check({nm, "_lat"}, 32'(n), 32'd5);
    check({nm, "_busy"}, 32'(bc), 32'd5);
    check({nm, "_res"}, data_result, er);
    check({nm, "_ovf"}, {31'd0, data_overflow}, {31'd0, eo});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rc;
    logic [31:0] r_op, cap;
    logic [4:0]  r_sh;
    logic        cap_o;

    reset        = 1'b1;
    ctrl_shift   = 1'b0;
    data_operand = '0;
    shift_amount = '0;
    repeat (2) @(negedge clock);
    check("rst_res", data_result, 32'h0);
    check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, data_overflow}, 32'd0);
    reset = 1'b0;

    run_op(32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, "s31");
    run_op(32'hF000_000F, 5'd4,  32'h0000_00F0, 1'b1, "s4ov");
    run_op(32'h0FFF_FFFF, 5'd4,  32'hFFFF_FFF0, 1'b0, "s4");
    run_op(32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, "s0");
    run_op(32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1'b1, "s1");

    // outputs hold in idle
    repeat (3) @(negedge clock);
    check("hold_res", data_result, 32'hFFFF_FFFE);
    check("hold_ovf", {31'd0, data_overflow}, 32'd1);

    // start pulse during SHIFT is ignored
    @(negedge clock);
    ctrl_shift   = 1'b1;
    data_operand = 32'h0000_0003;
    shift_amount = 5'd2;
    @(negedge clock);
    ctrl_shift = 1'b0;
    @(negedge clock);
    ctrl_shift   = 1'b1;
    data_operand = 32'hFFFF_FFFF;
    shift_amount = 5'd31;
    @(negedge clock);
    ctrl_shift = 1'b0;
    rc    = 0;
    cap   = '0;
    cap_o = 1'b0;
    repeat (12) begin
      if (data_resultRDY) begin
        rc++;
        cap   = data_result;
        cap_o = data_overflow;
      end
      @(negedge clock);
    end
    check("ign_cnt", 32'(rc), 32'd1);
    check("ign_res", cap, 32'h0000_000C);
    check("ign_ovf", {31'd0, cap_o}, 32'd0);

    // ctrl held high into DONE: back-to-back accept
    @(negedge clock);
    ctrl_shift   = 1'b1;
    data_operand = 32'h8000_0001;
    shift_amount = 5'd1;
    @(negedge clock);
    data_operand = 32'h5555_5555;
    shift_amount = 5'd3;
    n = 0;
    while (!data_resultRDY && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("b2b_a_lat", 32'(n), 32'd5);
    check("b2b_a_res", data_result, 32'h0000_0002);
    check("b2b_a_ovf", {31'd0, data_overflow}, 32'd1);
    data_operand = 32'h0000_0F0F;
    shift_amount = 5'd4;
    @(negedge clock);
    ctrl_shift = 1'b0;
    check("b2b_gap", {31'd0, busy}, 32'd1);
    n = 0;
    while (!data_resultRDY && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("b2b_b_lat", 32'(n), 32'd5);
    check("b2b_b_res", data_result, 32'h0000_F0F0);
    check("b2b_b_ovf", {31'd0, data_overflow}, 32'd0);

    // asynchronous reset in the middle of the stages
    @(negedge clock);
    ctrl_shift   = 1'b1;
    data_operand = 32'hDEAD_BEEF;
    shift_amount = 5'd13;
    @(negedge clock);
    ctrl_shift = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_res", data_result, 32'h0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("arst_ovf", {31'd0, data_overflow}, 32'd0);
    rc = 0;
    repeat (3) begin
      @(negedge clock);
      if (data_resultRDY) rc++;
    end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (data_resultRDY) rc++;
    end
    check("arst_nordy", 32'(rc), 32'd0);
    run_op(32'h0000_00FF, 5'd8, 32'h0000_FF00, 1'b0, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      r_op = $urandom;
      r_sh = 5'($urandom_range(0, 31));
      run_op(r_op, r_sh, gres(r_op, r_sh), gov(r_op, r_sh), "rand");
    end

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
